// File: rtl/sonar_pkg.sv
// ---------------------------------------------------------------------------
// sonar_pkg
// Shared types and helpers for the ultrasonic rangefinder scheduler.
//   state_e    : scheduler states (IDLE, TRIG, WAIT_ECHO, MEASURE, GAP)
//   DIST_W     : width of one distance slot in centimetres
//   DIST_MAX   : saturation value, also written on a timeout
//   max_int    : elaboration-time maximum, used to size the shared counter
//   sat_add    : unsigned add of two distances, saturated to DIST_MAX
//   avg_round  : rounded mean of two distances, (a+b+1)>>1
// ---------------------------------------------------------------------------
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        GAP
    } state_e;

    localparam int                DIST_W   = 10;
    localparam logic [DIST_W-1:0] DIST_MAX = 10'd1023;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One extra bit holds the carry; any carry means the sum is out of range.
    function automatic logic [DIST_W-1:0] sat_add(input logic [DIST_W-1:0] a,
                                                  input logic [DIST_W-1:0] b);
        logic [DIST_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DIST_W] ? DIST_MAX : sum[DIST_W-1:0];
    endfunction

    function automatic logic [DIST_W-1:0] avg_round(input logic [DIST_W-1:0] a,
                                                    input logic [DIST_W-1:0] b);
        logic [DIST_W:0] sum;
        sum = {1'b0, a} + {1'b0, b} + {{DIST_W{1'b0}}, 1'b1};
        return sum[DIST_W:1];
    endfunction

endpackage

// File: rtl/sonar_echo_sync.sv
// ---------------------------------------------------------------------------
// sonar_echo_sync
// Brings one asynchronous echo pin into the clock domain through two flops,
// then flags single-cycle rise and fall events on the synchronized level.
// Ports:
//   clock   in  system clock
//   resetn  in  asynchronous active-low reset
//   echo_i  in  raw echo pin (asynchronous)
//   rise_o  out one-cycle pulse on a synchronized 0->1 transition
//   fall_o  out one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module sonar_echo_sync (
    input  logic clock,
    input  logic resetn,
    input  logic echo_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchronizer chain into a single flop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Edges are decoded combinationally from the second stage so the
    // scheduler reacts on the same cycle the level becomes trustworthy.
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/sonar_scheduler.sv
// ---------------------------------------------------------------------------
// sonar_scheduler
// Round-robin scheduler for HC-SR04 style rangefinders sharing one time base.
// Fires one sensor at a time, times its echo pulse with a prescaled
// centimetre counter and publishes one registered distance per sensor.
// Ports:
//   clock       in  system clock
//   resetn      in  asynchronous active-low reset
//   enable      in  scheduler runs while high (sampled in IDLE / end of GAP)
//   echo        in  raw echo pins, asynchronous, one per sensor
//   trig        out trigger pins, registered, at most one bit high
//   distance    out per-sensor centimetres, sensor i in [10i+9:10i]
//   dist_valid  out one-cycle pulse when a distance slot updates
//   dist_idx    out index of the slot updated with dist_valid (held)
//   timeout     out sticky per-sensor flag: last measurement timed out
// Build option:
//   SONAR_SMOOTH_EN  when defined, non-timeout updates write the rounded mean
//                    of the old and new distance (first update after reset or
//                    after a timeout writes the new value directly).
// ---------------------------------------------------------------------------
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int NUM_SENSORS    = 2,
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int DIST_OFFSET    = 2,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GAP_CYCLES     = 500000
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          enable,
    input  logic [NUM_SENSORS-1:0]        echo,
    output logic [NUM_SENSORS-1:0]        trig,
    output logic [DIST_W*NUM_SENSORS-1:0] distance,
    output logic                          dist_valid,
    output logic [2:0]                    dist_idx,
    output logic [NUM_SENSORS-1:0]        timeout
);

    // One counter serves TRIG, WAIT_ECHO, MEASURE and GAP, so it is sized
    // for the longest of those intervals.
    localparam int CNT_LIM = max_int(max_int(TRIG_CYCLES, TIMEOUT_CYCLES), GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_LIM + 1);
    localparam int PRE_W   = $clog2(CYCLES_PER_CM + 1);

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CYCLES_PER_CM - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(NUM_SENSORS - 1);
    localparam logic [DIST_W-1:0] OFFSET    = DIST_W'(DIST_OFFSET);

    state_e                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [DIST_W-1:0]       cm_q, cm_d;
    logic [NUM_SENSORS-1:0]  trig_q, trig_d;
    logic                    valid_q;
    logic [2:0]              dist_idx_q;
    logic [NUM_SENSORS-1:0]  tout_q;
    logic [DIST_W-1:0]       dist_q [NUM_SENSORS];

    logic [NUM_SENSORS-1:0]  rise_vec, fall_vec;
    logic                    sel_rise, sel_fall;
    logic                    pre_wrap;
    logic [DIST_W-1:0]       cm_tick;
    logic                    upd, upd_tout;
    logic [DIST_W-1:0]       meas_cm;
    logic [DIST_W-1:0]       wr_dist;

    // ---------------------------------------------------------------------
    // Echo synchronizers, one per sensor
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sync
        sonar_echo_sync u_sync (
            .clock  (clock),
            .resetn (resetn),
            .echo_i (echo[i]),
            .rise_o (rise_vec[i]),
            .fall_o (fall_vec[i])
        );
    end

    // Only the currently fired sensor is listened to; all other echo
    // activity is dropped here.
    always_comb begin
        sel_rise = 1'b0;
        sel_fall = 1'b0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (idx_q == 3'(i)) begin
                sel_rise = rise_vec[i];
                sel_fall = fall_vec[i];
            end
        end
    end

    // Centimetre count including the current MEASURE cycle, so a fall seen
    // this cycle reports width/CYCLES_PER_CM exactly.
    assign pre_wrap = (pre_q == PRE_LAST);
    assign cm_tick  = (pre_wrap && cm_q != DIST_MAX) ? cm_q + DIST_W'(1) : cm_q;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        cm_d     = cm_q;
        upd      = 1'b0;
        upd_tout = 1'b0;
        meas_cm  = '0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                end
            end

            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = WAIT_ECHO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // A level already high on entry yields no rise pulse, so a stale
            // echo runs into the timeout instead of a bogus measurement.
            WAIT_ECHO: begin
                if (sel_rise) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    pre_d   = '0;
                    cm_d    = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d  = GAP;
                    cnt_d    = '0;
                    upd      = 1'b1;
                    upd_tout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            MEASURE: begin
                if (sel_fall) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    upd     = 1'b1;
                    meas_cm = cm_tick;
                end else if (cnt_q == TMO_LAST) begin
                    state_d  = GAP;
                    cnt_d    = '0;
                    upd      = 1'b1;
                    upd_tout = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    pre_d = pre_wrap ? '0 : pre_q + PRE_W'(1);
                    cm_d  = cm_tick;
                end
            end

            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                    state_d = enable ? TRIG : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Trigger is registered from the next state so the pin is glitch-free
    // and high for exactly the cycles spent in TRIG.
    always_comb begin
        trig_d = '0;
        if (state_d == TRIG) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (idx_d == 3'(i)) trig_d[i] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Value written into the addressed slot
    // ---------------------------------------------------------------------
`ifdef SONAR_SMOOTH_EN
    // have_q[i] marks a slot holding a real measurement that may be averaged.
    logic [NUM_SENSORS-1:0] have_q;
    logic [DIST_W-1:0]      old_dist;
    logic                   old_have;

    always_comb begin
        old_dist = '0;
        old_have = 1'b0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (idx_q == 3'(i)) begin
                old_dist = dist_q[i];
                old_have = have_q[i];
            end
        end
        if (upd_tout) begin
            wr_dist = DIST_MAX;
        end else if (old_have) begin
            wr_dist = avg_round(old_dist, sat_add(meas_cm, OFFSET));
        end else begin
            wr_dist = sat_add(meas_cm, OFFSET);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            have_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (upd && idx_q == 3'(i)) have_q[i] <= ~upd_tout;
            end
        end
    end
`else
    assign wr_dist = upd_tout ? DIST_MAX : sat_add(meas_cm, OFFSET);
`endif

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    // NOTE: the distance slots are reset explicitly because the paddle logic
    // reads them as 0 until the first measurement lands.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            pre_q      <= '0;
            cm_q       <= '0;
            trig_q     <= '0;
            valid_q    <= 1'b0;
            dist_idx_q <= '0;
            tout_q     <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) dist_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            cm_q    <= cm_d;
            trig_q  <= trig_d;
            valid_q <= upd;
            if (upd) dist_idx_q <= idx_q;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (upd && idx_q == 3'(i)) begin
                    dist_q[i] <= wr_dist;
                    tout_q[i] <= upd_tout;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_dist
        assign distance[i*DIST_W +: DIST_W] = dist_q[i];
    end

    assign trig       = trig_q;
    assign dist_valid = valid_q;
    assign dist_idx   = dist_idx_q;
    assign timeout    = tout_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sonar_scheduler
// Self-checking bench for sonar_scheduler. Each measurement is described by
// its kind (normal echo, no echo, over-long echo, stale echo, reset during
// measurement) and the expected result is derived from the pulse width with
// plain arithmetic. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sonar_scheduler;

    localparam int NS    = 2;
    localparam int TRIGC = 10;
    localparam int CPC   = 10;
    localparam int OFF   = 2;
    localparam int TMO   = 2000;
    localparam int GAPC  = 50;
    localparam int DMAX  = 1023;

    localparam int K_NORMAL = 0;
    localparam int K_NONE   = 1;
    localparam int K_LONG   = 2;
    localparam int K_STALE  = 3;
    localparam int K_RESET  = 4;

    logic            clock = 1'b0;
    logic            resetn;
    logic            enable;
    logic [NS-1:0]   echo;
    logic [NS-1:0]   trig;
    logic [10*NS-1:0] distance;
    logic            dist_valid;
    logic [2:0]      dist_idx;
    logic [NS-1:0]   timeout;

    sonar_scheduler #(
        .NUM_SENSORS    (NS),
        .TRIG_CYCLES    (TRIGC),
        .CYCLES_PER_CM  (CPC),
        .DIST_OFFSET    (OFF),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAPC)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .enable     (enable),
        .echo       (echo),
        .trig       (trig),
        .distance   (distance),
        .dist_valid (dist_valid),
        .dist_idx   (dist_idx),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int onehot_err = 0;
    int valid_seen = 0;
    int valid_exp  = 0;

    // Reference state: what each slot and flag should hold, and who fires next.
    int exp_dist  [NS];
    bit exp_tout  [NS];
    bit have_prev [NS];
    int exp_idx;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (resetn === 1'b1 && $countones(trig) > 1) onehot_err++;
        if (dist_valid === 1'b1) valid_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int width_to_cm(input int w);
        int v;
        v = w / CPC;
        if (v > DMAX) v = DMAX;
        v = v + OFF;
        if (v > DMAX) v = DMAX;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            exp_dist[i]  = 0;
            exp_tout[i]  = 1'b0;
            have_prev[i] = 1'b0;
        end
        exp_idx = 0;
    endtask

    task automatic model_update(input int s, input bit tmo, input int newv);
        valid_exp++;
        if (tmo) begin
            exp_dist[s]  = DMAX;
            exp_tout[s]  = 1'b1;
            have_prev[s] = 1'b0;
        end else begin
`ifdef SONAR_SMOOTH_EN
            if (have_prev[s]) newv = (exp_dist[s] + newv + 1) / 2;
`endif
            exp_dist[s]  = newv;
            exp_tout[s]  = 1'b0;
            have_prev[s] = 1'b1;
        end
    endtask

    task automatic check_slots();
        logic [NS-1:0] tv;
        for (int i = 0; i < NS; i++) begin
            check($sformatf("distance[%0d]", i), distance[10*i +: 10], exp_dist[i]);
            tv[i] = exp_tout[i];
        end
        check("timeout", timeout, tv);
    endtask

    // One full scheduler slot: trigger, echo stimulus, result check.
    task automatic run_meas(input int kind, input int w, input int dly,
                            input bit glitch, input bit drop_en);
        int s, o, n, hw, t0, lat, lat_exp, newv;
        bit tmo;
        logic [NS-1:0] want_t;
        s = exp_idx;
        o = (s + 1) % NS;
        newv = 0;
        tmo = 1'b1;
        lat_exp = TMO;

        n = 0;
        while (trig == '0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        want_t = '0;
        want_t[s] = 1'b1;
        check("trig_sel", trig, want_t);
        if (trig == '0) return;

        if (drop_en) enable = 1'b0;
        if (kind == K_STALE) echo[s] = 1'b1;
        hw = 0;
        while (trig != '0 && hw < 4 * TRIGC) begin
            hw++;
            @(negedge clock);
        end
        check("trig_width", hw, TRIGC);
        t0 = cyc;

        case (kind)
            K_NORMAL: begin
                repeat (dly) @(negedge clock);
                echo[s] = 1'b1;
                for (int k = 0; k < w; k++) begin
                    if (glitch && k == w / 2)     echo[o] = 1'b1;
                    if (glitch && k == w / 2 + 2) echo[o] = 1'b0;
                    @(negedge clock);
                end
                echo[o] = 1'b0;
                echo[s] = 1'b0;
                t0 = cyc;
                tmo = 1'b0;
                newv = width_to_cm(w);
                lat_exp = 3;
            end
            K_LONG: begin
                repeat (dly) @(negedge clock);
                echo[s] = 1'b1;
                t0 = cyc;
                lat_exp = TMO + 3;
            end
            K_RESET: begin
                repeat (dly) @(negedge clock);
                echo[s] = 1'b1;
                repeat (30) @(negedge clock);
                resetn = 1'b0;
                #1;
                check("rst_trig", trig, 0);
                check("rst_valid", dist_valid, 0);
                check("rst_dist_idx", dist_idx, 0);
                check("rst_timeout", timeout, 0);
                check("rst_distance", distance, 0);
                echo = '0;
                model_reset();
                @(negedge clock);
                resetn = 1'b1;
                return;
            end
            default: ; // K_NONE / K_STALE: nothing rises in WAIT_ECHO
        endcase

        n = 0;
        while (dist_valid !== 1'b1 && n < lat_exp + 50) begin
            @(negedge clock);
            n++;
        end
        lat = cyc - t0;
        check("valid_latency", lat, lat_exp);
        model_update(s, tmo, newv);
        check("dist_idx", dist_idx, s);
        check_slots();
        echo[s] = 1'b0;
        @(negedge clock);
        check("valid_pulse", dist_valid, 0);
        check("dist_idx_hold", dist_idx, s);
        exp_idx = (s + 1) % NS;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, kind, w;
        resetn = 1'b0;
        enable = 1'b0;
        echo   = '0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_trig", trig, 0);
        check("reset_valid", dist_valid, 0);
        check("reset_dist_idx", dist_idx, 0);
        check("reset_timeout", timeout, 0);
        check("reset_distance", distance, 0);
        resetn = 1'b1;

        n = 0;
        repeat (20) begin
            @(negedge clock);
            if (trig != '0) n++;
        end
        check("disabled_no_trig", n, 0);
        enable = 1'b1;

        // Directed cases
        run_meas(K_NORMAL, 120, 5, 1'b0, 1'b0);   // sensor 0 -> 14
        run_meas(K_NONE,   0,   0, 1'b0, 1'b0);   // sensor 1 -> timeout
        run_meas(K_NORMAL, 80,  0, 1'b0, 1'b0);   // sensor 0 -> 10
        run_meas(K_NORMAL, 50,  7, 1'b0, 1'b0);   // sensor 1 -> 7, flag clears
        run_meas(K_LONG,   0,  12, 1'b0, 1'b0);   // sensor 0 -> timeout
        run_meas(K_STALE,  0,   0, 1'b0, 1'b0);   // sensor 1 -> timeout
        run_meas(K_NORMAL, 200, 3, 1'b1, 1'b0);   // sensor 0 with glitch on 1
        run_meas(K_NORMAL, 99,  1, 1'b0, 1'b1);   // enable drops mid-measure

        n = 0;
        repeat (300) begin
            @(negedge clock);
            if (trig != '0) n++;
        end
        check("idle_no_trig", n, 0);
        enable = 1'b1;

        run_meas(K_NORMAL, 20,  4, 1'b0, 1'b0);   // sensor 0 after re-enable
        run_meas(K_RESET,  0,   6, 1'b0, 1'b0);   // reset during MEASURE
        run_meas(K_NORMAL, 200, 2, 1'b0, 1'b0);   // restart fires sensor 0 -> 22
        run_meas(K_NORMAL, 100, 2, 1'b0, 1'b0);   // sensor 1 -> 12
        run_meas(K_NORMAL, 100, 2, 1'b0, 1'b0);   // sensor 0: smoothed when enabled

        // Randomized traffic
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(0, 9);
            if (n <= 5)      kind = K_NORMAL;
            else if (n == 6) kind = K_NONE;
            else if (n == 7) kind = K_LONG;
            else if (n == 8) kind = K_STALE;
            else             kind = K_NORMAL;
            w = $urandom_range(5, 400);
            run_meas(kind, w, $urandom_range(0, 100), n == 9, 1'b0);
        end

        check("trig_onehot", onehot_err, 0);
        check("valid_count", valid_seen, valid_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
